// File: rtl/led_round_controller.sv
// Reaction-game round sequencer: random pre-light delay, one lit LED per round,
// hit/timeout scoring, and a one-cycle done pulse after the final round.
module led_round_controller #(
  parameter int unsigned NUM_LEDS    = 10,
  parameter int unsigned NUM_ROUNDS  = 10,
  parameter int unsigned MIN_DELAY   = 25_000_000,
  parameter int unsigned DELAY_SHIFT = 14,
  parameter int unsigned ON_CYCLES   = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 12_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [10:0]         random_value,
  input  logic [NUM_LEDS-1:0] hit,
  output logic [NUM_LEDS-1:0] led_enable,
  output logic                busy,
  output logic [7:0]          round_idx,
  output logic [7:0]          score,
  output logic [7:0]          misses,
  output logic                done
);

  localparam int unsigned TGT_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_LIT   = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [TGT_W-1:0]   target_q, target_d;
  logic [7:0]         round_q, round_d;
  logic [7:0]         score_q, score_d;
  logic [7:0]         misses_q, misses_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  function automatic logic [31:0] delay_of(input logic [10:0] rv);
    return 32'(MIN_DELAY) + ({21'd0, rv} << DELAY_SHIFT);
  endfunction

  function automatic logic [TGT_W-1:0] target_of(input logic [10:0] rv);
    logic [31:0] m;
    m = {21'd0, rv} % 32'(NUM_LEDS);
    return m[TGT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      round_q  <= '0;
      score_q  <= '0;
      misses_q <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      round_q  <= round_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The counter holds the cycles remaining in the current state, so a value of 1
  // marks the final cycle and the transition happens on that edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    round_d  = round_q;
    score_d  = score_q;
    misses_d = misses_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            round_d  = '0;
            score_d  = '0;
            misses_d = '0;
            cnt_d    = delay_of(random_value);
            state_d  = S_DELAY;
          end
        end
        S_DELAY: begin
          if (cnt_q <= 32'd1) begin
            target_d = target_of(random_value);
            cnt_d    = 32'(ON_CYCLES);
            state_d  = S_LIT;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_LIT: begin
          if (hit[target_q]) begin
            score_d = score_q + 8'd1;
            cnt_d   = 32'(GAP_CYCLES);
            state_d = S_GAP;
          end else if (cnt_q <= 32'd1) begin
            misses_d = misses_q + 8'd1;
            cnt_d    = 32'(GAP_CYCLES);
            state_d  = S_GAP;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_GAP: begin
          if (cnt_q <= 32'd1) begin
            round_d = round_q + 8'd1;
            if (round_d == 8'(NUM_ROUNDS)) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = delay_of(random_value);
              state_d = S_DELAY;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    led_d = '0;
    if (state_d == S_LIT) led_d[target_d] = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign led_enable = led_q;
  assign busy       = busy_q;
  assign round_idx  = round_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign done       = done_q;

endmodule

// File: tb/tb_led_round_controller.sv
// Bench for led_round_controller: directed game scenarios with literal checks,
// then randomized play, all checked every cycle against a round-by-round model.
module tb_led_round_controller;

  localparam int NL    = 4;
  localparam int NR    = 3;
  localparam int MIN_D = 2;
  localparam int SH    = 0;
  localparam int ONC   = 8;
  localparam int GAPC  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [10:0]   random_value = '0;
  logic [NL-1:0] hit = '0;
  logic [NL-1:0] led_enable;
  logic          busy;
  logic [7:0]    round_idx;
  logic [7:0]    score;
  logic [7:0]    misses;
  logic          done;

  led_round_controller #(
    .NUM_LEDS(NL), .NUM_ROUNDS(NR), .MIN_DELAY(MIN_D),
    .DELAY_SHIFT(SH), .ON_CYCLES(ONC), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .random_value(random_value), .hit(hit), .led_enable(led_enable),
    .busy(busy), .round_idx(round_idx), .score(score), .misses(misses),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected outputs as they should appear after each rising edge.
  logic [NL-1:0] exp_led   = '0;
  logic          exp_busy  = 1'b0;
  logic          exp_done  = 1'b0;
  logic [7:0]    exp_round = '0;
  logic [7:0]    exp_score = '0;
  logic [7:0]    exp_miss  = '0;

  task automatic tick(output bit k);
    @(posedge clk or negedge rst_n);
    k = 1'b0;
    if (!rst_n) begin
      exp_led = '0; exp_busy = 1'b0; exp_done = 1'b0;
      exp_round = '0; exp_score = '0; exp_miss = '0;
      k = 1'b1;
    end else if (abort) begin
      exp_led = '0; exp_busy = 1'b0; exp_done = 1'b0;
      k = 1'b1;
    end
  endtask

  task automatic play_game(input logic [10:0] rv0);
    bit k;
    int d;
    int tgt;
    logic [10:0] rv;
    rv = rv0;
    forever begin
      d = MIN_D + (int'(rv) << SH);
      for (int i = 1; i <= d; i++) begin
        tick(k);
        if (k) return;
      end
      tgt = int'(random_value) % NL;
      exp_led = NL'(1 << tgt);
      for (int i = 1; i <= ONC; i++) begin
        tick(k);
        if (k) return;
        if (hit[tgt]) begin
          exp_score++;
          exp_led = '0;
          break;
        end
        if (i == ONC) begin
          exp_miss++;
          exp_led = '0;
        end
      end
      for (int i = 1; i <= GAPC; i++) begin
        tick(k);
        if (k) return;
      end
      exp_round++;
      if (exp_round == 8'(NR)) break;
      rv = random_value;
    end
    exp_done = 1'b1;
    tick(k);
    if (k) return;
    exp_done = 1'b0;
    exp_busy = 1'b0;
  endtask

  initial begin : model
    bit k;
    forever begin
      tick(k);
      if (!k && start) begin
        exp_score = '0; exp_miss = '0; exp_round = '0;
        exp_busy = 1'b1; exp_done = 1'b0;
        play_game(random_value);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_led",    32'(led_enable), 32'(exp_led));
    chk("cyc_busy",   32'(busy),       32'(exp_busy));
    chk("cyc_done",   32'(done),       32'(exp_done));
    chk("cyc_round",  32'(round_idx),  32'(exp_round));
    chk("cyc_score",  32'(score),      32'(exp_score));
    chk("cyc_misses", 32'(misses),     32'(exp_miss));
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wait_neg(3);
    chk("rst_led", 32'(led_enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_round", 32'(round_idx), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_misses", 32'(misses), 32'h0);
    rst_n = 1'b1;

    // Game A: D=7, target 1; round 1 timeout, round 2 hit, round 3 hit on last lit cycle
    @(negedge clk); random_value = 11'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("a_busy_c1", 32'(busy), 32'h1);
    chk("a_led_c1", 32'(led_enable), 32'h0);
    wait_neg(6); chk("a_led_c7", 32'(led_enable), 32'h0);
    wait_neg(1); chk("a_led_c8", 32'(led_enable), 32'h2);
    wait_neg(7); chk("a_led_c15", 32'(led_enable), 32'h2);
    wait_neg(1);
    chk("a_led_c16", 32'(led_enable), 32'h0);
    chk("a_miss_c16", 32'(misses), 32'h1);
    wait_neg(4);
    chk("a_round_c20", 32'(round_idx), 32'h1);
    chk("a_busy_c20", 32'(busy), 32'h1);
    wait_neg(7); chk("a_led_c27", 32'(led_enable), 32'h2); hit = 4'b0101;
    wait_neg(1);
    chk("a_led_c28", 32'(led_enable), 32'h2);
    chk("a_score_c28", 32'(score), 32'h0);
    wait_neg(1); chk("a_led_c29", 32'(led_enable), 32'h2); hit = 4'b0010;
    wait_neg(1);
    chk("a_led_c30", 32'(led_enable), 32'h0);
    chk("a_score_c30", 32'(score), 32'h1);
    hit = 4'b0000;
    wait_neg(18); chk("a_led_c48", 32'(led_enable), 32'h2); hit = 4'b0010;
    wait_neg(1);
    chk("a_led_c49", 32'(led_enable), 32'h0);
    chk("a_score_c49", 32'(score), 32'h2);
    chk("a_miss_c49", 32'(misses), 32'h1);
    hit = 4'b0000;
    wait_neg(4);
    chk("a_done_c53", 32'(done), 32'h1);
    chk("a_round_c53", 32'(round_idx), 32'h3);
    wait_neg(1);
    chk("a_done_c54", 32'(done), 32'h0);
    chk("a_busy_c54", 32'(busy), 32'h0);
    chk("a_score_c54", 32'(score), 32'h2);
    chk("a_miss_c54", 32'(misses), 32'h1);
    chk("a_round_c54", 32'(round_idx), 32'h3);

    // Game B: restart clears counters, one hit, then abort mid-LIT of round 2
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("b_score_c1", 32'(score), 32'h0);
    chk("b_miss_c1", 32'(misses), 32'h0);
    chk("b_round_c1", 32'(round_idx), 32'h0);
    wait_neg(7); hit = 4'b0010;
    wait_neg(1); chk("b_score_c9", 32'(score), 32'h1); hit = 4'b0000;
    wait_neg(13); chk("b_led_c22", 32'(led_enable), 32'h2); abort = 1'b1;
    wait_neg(1);
    abort = 1'b0;
    chk("b_abort_led", 32'(led_enable), 32'h0);
    chk("b_abort_busy", 32'(busy), 32'h0);
    chk("b_abort_score", 32'(score), 32'h1);
    chk("b_abort_round", 32'(round_idx), 32'h1);
    wait_neg(3); chk("b_abort_done", 32'(done), 32'h0);
    start = 1'b1; abort = 1'b1;
    wait_neg(1);
    start = 1'b0; abort = 1'b0;
    chk("b_sa_busy", 32'(busy), 32'h0);
    chk("b_sa_score", 32'(score), 32'h1);

    // Async reset in the middle of DELAY, then a fresh game with D=5, target 3
    random_value = 11'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_neg(2);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("r_busy", 32'(busy), 32'h0);
    chk("r_led", 32'(led_enable), 32'h0);
    chk("r_score", 32'(score), 32'h0);
    chk("r_round", 32'(round_idx), 32'h0);
    @(negedge clk); rst_n = 1'b1; random_value = 11'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("r_busy_c1", 32'(busy), 32'h1);
    wait_neg(4); chk("r_led_c5", 32'(led_enable), 32'h0);
    wait_neg(1); chk("r_led_c6", 32'(led_enable), 32'h8);

    // Randomized play against the model
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      random_value = 11'($urandom_range(0, 31));
      start = ($urandom_range(0, 7) == 0);
      hit   = ($urandom_range(0, 4) == 0) ? NL'($urandom) : '0;
      abort = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    start = 1'b0; hit = '0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_neg(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
